// File: rtl/tdc_event_reader.sv
// rtl/tdc_event_reader.sv - TDC channel readout FSM feeding a FWFT event FIFO; optional TOT filter via TDC_READER_TOT_FILTER_EN
module tdc_event_reader #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MIN_TOT    = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tdc_has_event,
    input  logic [3:0]  tdc_chan,
    input  logic [31:0] tdc_timestamp,
    input  logic [31:0] tdc_tot,
    output logic        tdc_clear,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [67:0] evt_data,
    output logic [4:0]  fifo_level,
    output logic [15:0] filtered_count
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

`ifdef TDC_READER_TOT_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          capture;
    logic          tot_low;
    logic          filtered;
    logic          push;
    logic          pop;
    logic [67:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level;
    logic [15:0]   fcnt;

    // Short events are still released from the TDC, they just never reach the FIFO.
    assign tot_low  = (tdc_tot < MIN_TOT);
    assign filtered = FILTER_EN & tot_low;

    // Eligibility looks only at the registered level, so a pop cannot make room in the same cycle.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && tdc_has_event && (level < DEPTH_L)) begin
                    capture    = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR:    state_next = WAIT_LOW;
            WAIT_LOW: if (!tdc_has_event) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // State register; tdc_clear comes straight from a flop and is held high during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tdc_clear <= 1'b1;
        end else begin
            state     <= state_next;
            tdc_clear <= (state_next == CLEAR);
        end
    end

    assign push = capture & ~filtered;
    assign pop  = evt_valid & evt_ready;

    // Storage array; no reset needed because reads are masked by evt_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tdc_chan, tdc_timestamp, tdc_tot};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
        end
    end

`ifdef TDC_READER_TOT_FILTER_EN
    // Count of discarded short events, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt <= '0;
        end else if (capture && filtered && (fcnt != 16'hFFFF)) begin
            fcnt <= fcnt + 16'd1;
        end
    end
`else
    assign fcnt = '0;
`endif

    assign evt_valid      = (level != 5'd0);
    assign evt_data       = evt_valid ? mem[rd_ptr] : 68'd0;
    assign fifo_level     = level;
    assign filtered_count = fcnt;

endmodule

// File: doc/tdc_event_reader.md
TDC_EVENT_READER -- requirements
Module: tdc_event_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event buffer depth (power of 2, 2..16).
REQ-002 SHALL have parameter MIN_TOT, default 32'd16, minimum accepted time-over-threshold (filter build only).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  readout enable; 0 = no new captures.
REQ-006 SHALL have port tdc_has_event  input  1  TDC channel holds a completed event.
REQ-007 SHALL have port tdc_chan  input  4  TDC channel number.
REQ-008 SHALL have port tdc_timestamp  input  32  event timestamp.
REQ-009 SHALL have port tdc_tot  input  32  event time-over-threshold.
REQ-010 SHALL have port tdc_clear  output  1  clear strobe to TDC channel (releases event).
REQ-011 SHALL have port evt_valid  output  1  buffered event available.
REQ-012 SHALL have port evt_ready  input  1  downstream accepts event.
REQ-013 SHALL have port evt_data  output  68  {chan[67:64], timestamp[63:32], tot[31:0]} of head entry.
REQ-014 SHALL have port fifo_level  output  5  number of buffered events.
REQ-015 SHALL have port filtered_count  output  16  events discarded by TOT filter.

Function
REQ-016 SHALL implement FSM states IDLE, CLEAR, WAIT_LOW.
REQ-017 IDLE -> CLEAR SHALL occur when enable & tdc_has_event & (fifo_level < FIFO_DEPTH); that cycle the inputs SHALL be written to the FIFO (or discarded per REQ-030).
REQ-018 IDLE with tdc_has_event & full FIFO SHALL hold in IDLE without asserting tdc_clear (backpressure; TDC keeps its event).
REQ-019 CLEAR SHALL drive tdc_clear=1 for exactly one cycle, then go to WAIT_LOW.
REQ-020 WAIT_LOW SHALL drive tdc_clear=0 and return to IDLE on the first cycle tdc_has_event=0; an event SHALL never be captured twice.
REQ-021 tdc_clear SHALL be registered and glitch-free.
REQ-022 Capture-to-evt_valid latency SHALL be 1 cycle when FIFO was empty (first-word fall-through).
REQ-023 evt_valid SHALL equal (fifo_level != 0); a pop SHALL occur on evt_valid & evt_ready.
REQ-024 evt_data SHALL remain stable while evt_valid=1 & evt_ready=0.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order.
REQ-026 Push eligibility SHALL use the registered fifo_level; a same-cycle pop SHALL NOT enable a push into a full FIFO.
REQ-027 Pop on empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 enable falling mid-handshake (CLEAR/WAIT_LOW) SHALL let the sequence complete.

Reset
REQ-029 reset=1 SHALL set state IDLE, FIFO empty, fifo_level=0, evt_valid=0, evt_data=0, filtered_count=0, and drive tdc_clear=1 while reset is high so the TDC is cleared too.

Configuration
REQ-030 With macro TDC_READER_TOT_FILTER_EN defined, an event with tdc_tot < MIN_TOT SHALL still be cleared (CLEAR, WAIT_LOW) but not written; filtered_count SHALL increment, saturating at 16'hFFFF.
REQ-031 Without TDC_READER_TOT_FILTER_EN every event SHALL be written and filtered_count SHALL be constant 0.

Verification
REQ-032 Event chan=0, ts=25505, tot=199099, evt_ready=1 -> one tdc_clear pulse 1 cycle after capture; evt_data={4'd0,32'd25505,32'd199099}; evt_valid one cycle.
REQ-033 evt_ready=0, 5 events with depth 4 -> fifo_level=4; 5th event held (no tdc_clear) until one pop; then captured, order ts preserved.
REQ-034 tdc_has_event held high 3 cycles after clear -> exactly one FIFO entry, FSM in WAIT_LOW until low.
REQ-035 Filter build, MIN_TOT=16, tots 15,16,100 -> two entries (16,100), filtered_count=1, three tdc_clear pulses; non-filter build -> three entries, count 0.
REQ-036 reset asserted in CLEAR with 2 buffered -> next cycle fifo_level=0, evt_valid=0, tdc_clear=1 during reset, FSM IDLE after.
